// File: rtl/matmul_arb.sv
// matmul_arb: shares one matmul unit (clarke / inv-clarke / park / inv-park,
// op 0..3) among N_REQ requesters. Round-robin arbitration, one operation
// outstanding at a time, watchdog abort when the unit never answers.
//
// Ports
//   clk, rstb                  clock, synchronous active-low reset
//   req_valid/op/a/b           per-requester request, packed by requester index
//   req_ready                  one-cycle accept pulse, one-hot
//   rsp_valid                  one-cycle result pulse to the granted requester
//   rsp_a, rsp_b, rsp_err      shared result bus; rsp_err flags a watchdog abort
//   mm_start/op/a/b            command to the matmul unit (operands held)
//   mm_a_out, mm_b_out, mm_done  result from the matmul unit
//   busy                       high while an operation is in WAIT or RESP
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | scanning requests from rr_ptr, issue to matmul on a winner
// WAIT  | operation in flight, watchdog running, waiting for mm_done
// RESP  | result (or abort) latched, pulse rsp_valid to the granted requester

module matmul_arb #(
    parameter int D_WIDTH = 16,
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [2*N_REQ-1:0]         req_op,
    input  logic [D_WIDTH*N_REQ-1:0]   req_a,
    input  logic [D_WIDTH*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [D_WIDTH-1:0]         rsp_a,
    output logic [D_WIDTH-1:0]         rsp_b,
    output logic                       rsp_err,
    output logic                       mm_start,
    output logic [1:0]                 mm_op,
    output logic [D_WIDTH-1:0]         mm_a,
    output logic [D_WIDTH-1:0]         mm_b,
    input  logic [D_WIDTH-1:0]         mm_a_out,
    input  logic [D_WIDTH-1:0]         mm_b_out,
    input  logic                       mm_done,
    output logic                       busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [PTR_W-1:0]     rr_ptr, rr_ptr_nxt;
    logic [PTR_W-1:0]     gnt, gnt_nxt;
    logic [WD_W-1:0]      wd, wd_nxt, wd_inc;
    logic                 tmo, tmo_nxt;

    logic [N_REQ-1:0]     req_ready_nxt;
    logic [N_REQ-1:0]     rsp_valid_nxt;
    logic [D_WIDTH-1:0]   rsp_a_nxt, rsp_b_nxt;
    logic                 rsp_err_nxt;
    logic                 mm_start_nxt;
    logic [1:0]           mm_op_nxt;
    logic [D_WIDTH-1:0]   mm_a_nxt, mm_b_nxt;
    logic                 busy_nxt;

    // Round-robin winner: rotate the request vector so rr_ptr lands at bit 0,
    // take the first set bit, then map it back to an absolute index.
    logic [N_REQ-1:0]     rot;
    logic                 found;
    logic [PTR_W-1:0]     win;
    logic [PTR_W:0]       sum;
    logic [1:0]           sel_op;
    logic [D_WIDTH-1:0]   sel_a, sel_b;

    always_comb begin
        rot   = N_REQ'({req_valid, req_valid} >> rr_ptr);
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, rr_ptr} + (PTR_W+1)'(k);
                if (sum >= (PTR_W+1)'(N_REQ)) begin
                    sum = sum - (PTR_W+1)'(N_REQ);
                end
                win = sum[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win == PTR_W'(k)) begin
                sel_op = req_op[2*k +: 2];
                sel_a  = req_a[D_WIDTH*k +: D_WIDTH];
                sel_b  = req_b[D_WIDTH*k +: D_WIDTH];
            end
        end
    end

    assign wd_inc = wd + WD_W'(1);

    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        gnt_nxt       = gnt;
        wd_nxt        = wd;
        tmo_nxt       = tmo;
        req_ready_nxt = '0;
        rsp_valid_nxt = '0;
        rsp_a_nxt     = rsp_a;
        rsp_b_nxt     = rsp_b;
        rsp_err_nxt   = 1'b0;
        mm_start_nxt  = 1'b0;
        mm_op_nxt     = mm_op;
        mm_a_nxt      = mm_a;
        mm_b_nxt      = mm_b;

        unique case (state)
            IDLE: begin
                if (found) begin
                    req_ready_nxt = N_REQ'(1) << win;
                    mm_start_nxt  = 1'b1;
                    mm_op_nxt     = sel_op;
                    mm_a_nxt      = sel_a;
                    mm_b_nxt      = sel_b;
                    gnt_nxt       = win;
                    wd_nxt        = '0;
                    tmo_nxt       = 1'b0;
                    state_nxt     = WAIT;
                end
            end
            WAIT: begin
                wd_nxt = wd_inc;
                // done beats the watchdog when both land on the same cycle
                if (mm_done) begin
                    rsp_a_nxt = mm_a_out;
                    rsp_b_nxt = mm_b_out;
                    tmo_nxt   = 1'b0;
                    state_nxt = RESP;
                end else if (wd_inc == WD_W'(TIMEOUT - 1)) begin
                    rsp_a_nxt = '0;
                    rsp_b_nxt = '0;
                    tmo_nxt   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid_nxt = N_REQ'(1) << gnt;
                rsp_err_nxt   = tmo;
                rr_ptr_nxt    = (gnt == PTR_W'(N_REQ - 1)) ? '0 : gnt + PTR_W'(1);
                wd_nxt        = '0;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt == WAIT) || (state_nxt == RESP);
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt       <= '0;
            wd        <= '0;
            tmo       <= 1'b0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_a     <= '0;
            rsp_b     <= '0;
            rsp_err   <= 1'b0;
            mm_start  <= 1'b0;
            mm_op     <= '0;
            mm_a      <= '0;
            mm_b      <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            gnt       <= gnt_nxt;
            wd        <= wd_nxt;
            tmo       <= tmo_nxt;
            req_ready <= req_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_a     <= rsp_a_nxt;
            rsp_b     <= rsp_b_nxt;
            rsp_err   <= rsp_err_nxt;
            mm_start  <= mm_start_nxt;
            mm_op     <= mm_op_nxt;
            mm_a      <= mm_a_nxt;
            mm_b      <= mm_b_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule
